// File: rtl/cat_recognizer_ctrl.sv
// Cat recognizer control: APB register/memory-load decode, file fetch sequencer
// streaming memory words into the MAC engine, and verdict capture into STATUS.
`timescale 1ns/1ps
module cat_recognizer_ctrl #(
    parameter int Amba_Word       = 24,
    parameter int Amba_Addr_Depth = 13,
    parameter int file_length     = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [Amba_Addr_Depth-1:0] PADDR,
    input  logic [Amba_Word-1:0]       PWDATA,
    output logic [Amba_Word-1:0]       PRDATA,
    output logic                       mem_we,
    output logic [Amba_Addr_Depth-1:0] mem_addr,
    output logic [Amba_Word-1:0]       mem_wdata,
    input  logic [Amba_Word-1:0]       mem_rdata,
    output logic                       eng_clear,
    output logic                       eng_valid,
    output logic [Amba_Word-1:0]       eng_data,
    output logic                       eng_last,
    input  logic                       eng_done,
    input  logic                       eng_result,
    output logic                       busy
);

    localparam logic [Amba_Addr_Depth-1:0] LAST_ADDR = Amba_Addr_Depth'(file_length);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_DRAIN,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                       state_reg, state_next;
    logic [Amba_Addr_Depth-1:0]   cnt_reg;
    logic                         start_req_reg;
    logic                         mem_we_reg;
    logic [Amba_Addr_Depth-1:0]   wr_addr_reg;
    logic [Amba_Word-1:0]         wr_data_reg;
    logic                         valid_reg;
    logic                         done_reg;
    logic                         result_reg;
    logic [Amba_Word-1:0]         prdata_reg;
    logic [Amba_Word-1:0]         status_word;

    logic apb_wr;
    logic idle_or_done;
    logic addr_is_ctrl;
    logic addr_in_image;
    logic start_hit;
    logic img_wr_hit;

    assign apb_wr        = PSEL & PENABLE & PWRITE;
    assign idle_or_done  = (state_reg == S_IDLE) || (state_reg == S_DONE);
    assign addr_is_ctrl  = (PADDR == '0);
    assign addr_in_image = (PADDR != '0) && (PADDR <= LAST_ADDR);
    // A start is pending for one cycle before CLEAR; hold off other writes meanwhile.
    assign start_hit     = apb_wr && addr_is_ctrl && PWDATA[0] && idle_or_done && !start_req_reg;
    assign img_wr_hit    = apb_wr && addr_in_image && idle_or_done && !start_req_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        eng_clear  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start_req_reg) begin
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                eng_clear  = 1'b1;
                busy       = 1'b1;
                state_next = S_FETCH;
            end
            S_FETCH: begin
                busy = 1'b1;
                if (cnt_reg == LAST_ADDR) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy       = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (eng_done) begin
                    state_next = S_DONE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg       <= '0;
            start_req_reg <= 1'b0;
            valid_reg     <= 1'b0;
        end else begin
            start_req_reg <= start_hit;
            valid_reg     <= (state_reg == S_FETCH);
            if (state_reg == S_CLEAR) begin
                cnt_reg <= Amba_Addr_Depth'(1);
            end else if (state_reg == S_FETCH) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Image load path: one registered write per accepted APB transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we_reg  <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            mem_we_reg <= img_wr_hit;
            if (img_wr_hit) begin
                wr_addr_reg <= PADDR;
                wr_data_reg <= PWDATA;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_reg   <= 1'b0;
            result_reg <= 1'b0;
        end else if (state_reg == S_CLEAR) begin
            done_reg   <= 1'b0;
            result_reg <= 1'b0;
        end else if ((state_reg == S_WAIT) && eng_done) begin
            done_reg   <= 1'b1;
            result_reg <= eng_result;
        end
    end

    always_comb begin
        status_word      = '0;
        status_word[2:0] = {result_reg, done_reg, busy};
    end

    // Loaded during the setup phase so the value is stable through the access phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prdata_reg <= '0;
        end else begin
            prdata_reg <= (PSEL && !PWRITE && addr_is_ctrl) ? status_word : '0;
        end
    end

    assign PRDATA    = prdata_reg;
    assign mem_we    = mem_we_reg;
    assign mem_wdata = wr_data_reg;
    assign mem_addr  = (state_reg == S_FETCH) ? cnt_reg : wr_addr_reg;
    assign eng_valid = valid_reg;
    assign eng_last  = (state_reg == S_DRAIN);

    generate
        for (genvar gi = 0; gi < Amba_Word; gi++) begin : g_eng_data
            assign eng_data[gi] = mem_rdata[gi] & valid_reg;
        end
    endgenerate

endmodule
